// File: rtl/cache_mem_responder_if.sv
// Request/response bus between the cache controller (master) and the memory responder (slave).
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid && ready, and once valid rises its payload holds until that edge.
interface cache_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Single-outstanding main-memory responder: fixed access latency, address error flagging,
// saturating read/write completion counters.
module cache_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_mem_responder_if.slave bus,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state, next_state;

  logic [7:0]        lat_cnt;
  logic              hold_we;
  logic [31:0]       hold_addr;
  logic [31:0]       hold_wdata;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] index;
  logic              addr_err;
  logic              commit;
  logic              resp_hs;

  assign index    = hold_addr[ADDR_W+1:2];
  assign addr_err = (hold_addr[1:0] != 2'b00) || (hold_addr[31:ADDR_W+2] != '0);
  assign commit   = (state == WAIT) && (lat_cnt == 8'd0);
  assign resp_hs  = (state == RESP) && bus.resp_ready;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req_valid) next_state = WAIT;
      WAIT:    if (lat_cnt == 8'd0) next_state = RESP;
      RESP:    if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt        <= 8'd0;
      hold_we        <= 1'b0;
      hold_addr      <= 32'd0;
      hold_wdata     <= 32'd0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      rd_count       <= '0;
      wr_count       <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        hold_we    <= bus.req_we;
        hold_addr  <= bus.req_addr;
        hold_wdata <= bus.req_wdata;
        lat_cnt    <= 8'(LATENCY - 1);
      end else if (state == WAIT && lat_cnt != 8'd0) begin
        lat_cnt <= lat_cnt - 8'd1;
      end

      if (commit) begin
        bus.resp_err   <= addr_err;
        bus.resp_rdata <= (!addr_err && !hold_we) ? mem[index] : 32'd0;
      end

      // Errored requests still count as completed accesses.
      if (resp_hs) begin
        bus.resp_err   <= 1'b0;
        bus.resp_rdata <= 32'd0;
        if (hold_we) begin
          if (wr_count != '1) wr_count <= wr_count + 1'b1;
        end else begin
          if (rd_count != '1) rd_count <= rd_count + 1'b1;
        end
      end
    end
  end

  // Array is not reset; an async reset forces state to IDLE so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (commit && hold_we && !addr_err) mem[index] <= hold_wdata;
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench: instance A (LATENCY=3, CNT_W=16) for the main scenarios,
// instance B (LATENCY=1, CNT_W=4) for single-cycle latency and counter saturation.
module tb_cache_mem_responder;

  localparam int LAT_A = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_mem_responder_if bus_a ();
  cache_mem_responder_if bus_b ();

  logic [15:0] rd_count_a, wr_count_a;
  logic [3:0]  rd_count_b, wr_count_b;
  logic [1:0]  state_a, state_b;

  cache_mem_responder #(.ADDR_W(10), .LATENCY(LAT_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
    .rd_count(rd_count_a), .wr_count(wr_count_a), .state_dbg(state_a)
  );

  cache_mem_responder #(.ADDR_W(10), .LATENCY(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
    .rd_count(rd_count_b), .wr_count(wr_count_b), .state_dbg(state_b)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rdata;

  // One request on instance A; checks latency, payload, hold under backpressure, and handshake.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit chk_data,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int n;
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    bus_a.req_we    = 1'bx;
    bus_a.req_addr  = 'x;
    bus_a.req_wdata = 'x;
    checks++;
    if (bus_a.req_ready !== 1'b0) begin
      errors++; $display("FAIL %s req_ready_after_accept: got %b want 0", name, bus_a.req_ready);
    end
    n = 0;
    while (bus_a.resp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != LAT_A) begin
      errors++; $display("FAIL %s latency: got %0d edges want %0d", name, n, LAT_A);
      if (n >= 40) return;
    end
    last_rdata = bus_a.resp_rdata;
    checks++;
    if (chk_data && bus_a.resp_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s resp_rdata: got %h want %h", name, bus_a.resp_rdata, exp_rdata);
    end
    checks++;
    if (bus_a.resp_err !== exp_err) begin
      errors++; $display("FAIL %s resp_err: got %b want %b", name, bus_a.resp_err, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus_a.resp_valid !== 1'b1 || bus_a.req_ready !== 1'b0 ||
          (chk_data && bus_a.resp_rdata !== exp_rdata) || bus_a.resp_err !== exp_err) begin
        errors++;
        $display("FAIL %s hold_cycle%0d: got valid=%b ready=%b rdata=%h err=%b want valid=1 ready=0 rdata=%h err=%b",
                 name, i, bus_a.resp_valid, bus_a.req_ready, bus_a.resp_rdata, bus_a.resp_err, exp_rdata, exp_err);
      end
    end
    bus_a.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b0;
    checks++;
    if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1 ||
        bus_a.resp_rdata !== 32'd0 || bus_a.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL %s after_handshake: got valid=%b ready=%b rdata=%h err=%b want 0 1 0 0",
               name, bus_a.resp_valid, bus_a.req_ready, bus_a.resp_rdata, bus_a.resp_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_a.resp_valid !== 1'b0 || rd_count_a !== 16'd0 || wr_count_a !== 16'd0 || state_a !== 2'd0) begin
      errors++; $display("FAIL reset_hold: got valid=%b rd=%0d wr=%0d state=%0d want 0 0 0 0",
                         bus_a.resp_valid, rd_count_a, wr_count_a, state_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_a.req_ready !== 1'b1 || bus_a.resp_valid !== 1'b0 || bus_a.resp_rdata !== 32'd0 ||
        bus_a.resp_err !== 1'b0 || rd_count_a !== 16'd0 || wr_count_a !== 16'd0) begin
      errors++; $display("FAIL reset_release: got ready=%b valid=%b rdata=%h err=%b rd=%0d wr=%0d want 1 0 0 0 0 0",
                         bus_a.req_ready, bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err, rd_count_a, wr_count_a);
    end
  endtask

  task automatic test_round_trip();
    do_req("wr_0x10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 0);
    do_req("rd_0x10", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    checks++;
    if (wr_count_a !== 16'd1 || rd_count_a !== 16'd1) begin
      errors++; $display("FAIL round_trip_counts: got wr=%0d rd=%0d want 1 1", wr_count_a, rd_count_a);
    end
  endtask

  task automatic test_backpressure();
    do_req("rd_backpressure", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5);
  endtask

  task automatic test_illegal();
    do_req("rd_out_of_range", 1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0, 1'b1, 0);
    do_req("wr_misaligned", 1'b1, 32'h0000_0012, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 0);
    do_req("rd_0x10_intact", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    do_req("rd_0x10_word", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    checks++;
    if (rd_count_a !== 16'd5 || wr_count_a !== 16'd2) begin
      errors++; $display("FAIL illegal_counts: got rd=%0d wr=%0d want 5 2", rd_count_a, wr_count_a);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = 1'b1;
    bus_a.req_addr  = 32'h0000_0020;
    bus_a.req_wdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1 || wr_count_a !== 16'd0 ||
        rd_count_a !== 16'd0 || state_a !== 2'd0) begin
      errors++; $display("FAIL async_reset_clear: got valid=%b ready=%b wr=%0d rd=%0d state=%0d want 0 1 0 0 0",
                         bus_a.resp_valid, bus_a.req_ready, wr_count_a, rd_count_a, state_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus_a.resp_valid !== 1'b0 || wr_count_a !== 16'd0) begin
        errors++; $display("FAIL aborted_no_resp%0d: got valid=%b wr=%0d want 0 0", i, bus_a.resp_valid, wr_count_a);
      end
    end
    do_req("rd_0x10_after_reset", 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
    do_req("rd_0x20_aborted", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    checks++;
    if (last_rdata === 32'hAAAA_5555) begin
      errors++; $display("FAIL aborted_write_committed: got %h want anything but AAAA5555", last_rdata);
    end
    do_req("wr_0x20", 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b1, 32'h0, 1'b0, 0);
    do_req("rd_0x20", 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h1111_2222, 1'b0, 0);
    checks++;
    if (wr_count_a !== 16'd1 || rd_count_a !== 16'd3) begin
      errors++; $display("FAIL post_reset_counts: got wr=%0d rd=%0d want 1 3", wr_count_a, rd_count_a);
    end
  endtask

  // Instance B: one-edge latency and 4-bit counter saturation.
  task automatic test_saturation();
    logic [3:0] exp_rd;
    for (int k = 0; k <= 17; k++) begin
      bus_b.req_valid = 1'b1;
      bus_b.req_we    = (k == 0);
      bus_b.req_addr  = 32'h0000_0004;
      bus_b.req_wdata = 32'hCAFE_0001;
      @(posedge clk); #1;
      bus_b.req_valid = 1'b0;
      checks++;
      if (bus_b.resp_valid !== 1'b0) begin
        errors++; $display("FAIL sat_early_resp%0d: got %b want 0", k, bus_b.resp_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_b.resp_valid !== 1'b1 || bus_b.resp_rdata !== ((k == 0) ? 32'h0 : 32'hCAFE_0001)) begin
        errors++; $display("FAIL sat_resp%0d: got valid=%b rdata=%h want 1 %h", k, bus_b.resp_valid,
                           bus_b.resp_rdata, (k == 0) ? 32'h0 : 32'hCAFE_0001);
      end
      bus_b.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_b.resp_ready = 1'b0;
      exp_rd = (k > 15) ? 4'd15 : 4'(k);
      checks++;
      if (rd_count_b !== exp_rd || wr_count_b !== 4'd1) begin
        errors++; $display("FAIL sat_count%0d: got rd=%0d wr=%0d want %0d 1", k, rd_count_b, wr_count_b, exp_rd);
      end
    end
  endtask

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.resp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.resp_ready = 1'b0;
    last_rdata = '0;
    test_reset();
    test_round_trip();
    test_backpressure();
    test_illegal();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
Main-memory responder at the memory end of the cache refill/write-through path. It accepts one word-sized read or write request at a time from the cache controller over a valid/ready handshake. Each request is serviced after a fixed, parameterised access latency, and a handshaked response carries read data or a write acknowledge. The block also flags illegal addresses and keeps saturating read/write access counters for performance monitoring.

Parameters:
ADDR_W, 10, word-index width; memory holds 2**ADDR_W 32-bit words
LATENCY, 3, cycles from request acceptance to resp_valid assertion; legal range 1..255
CNT_W, 16, width of rd_count / wr_count

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2]
req_wdata  input  32  write data
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  read data; 0 for writes and errored requests
resp_err  output  1  request had an illegal address
rd_count  output  CNT_W  completed read responses, saturating
wr_count  output  CNT_W  completed write responses, saturating

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, req_ready=1 once out of reset, resp_valid=0, resp_rdata=0, resp_err=0, rd_count=0, wr_count=0, latency counter=0. Memory array contents are NOT reset.
- Reset asserted mid-operation aborts the in-flight request. No response is produced, and no memory write occurs if the abort comes before commit.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 (combinational from state).
  - On an edge with req_valid&&req_ready: capture we/addr/wdata into holding registers, load the counter with LATENCY-1, go to WAIT.
  - req_* may change freely after acceptance.
- WAIT:
  - req_ready=0. Counter decrements each cycle.
  - On the edge where the counter is 0, perform the operation and go to RESP.
  - The operation is performed with captured values:
    - error = captured addr[1:0]!=0 OR addr[31:ADDR_W+2]!=0.
    - Read, no error: resp_rdata <= mem[index].
    - Write, no error: mem[index] <= wdata, resp_rdata <= 0.
    - Error: memory untouched, resp_rdata <= 0, resp_err <= 1.
  - Net latency: request accepted at edge N gives resp_valid high after edge N+LATENCY. With LATENCY=1, WAIT lasts one cycle.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are stable while resp_ready=0; the response stays held indefinitely (backpressure).
  - On an edge with resp_ready=1: resp_valid<=0, resp_err<=0, resp_rdata<=0, go to IDLE.
  - On that same edge, increment rd_count (read) or wr_count (write), including errored requests. Counters saturate at all-ones.
  - req_ready returns to 1 the cycle after the handshake. No back-to-back overlap: at most one request outstanding.
- Ordering: a read following a write to the same word returns the written data, since the write commits before its response.
- X/undefined req_* inputs while req_valid=0 are ignored.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release -> req_ready=1, resp_valid=0, rd_count=wr_count=0; assert rst_n low asynchronously mid-cycle -> outputs clear without a clock edge.
- Write/read round trip (LATENCY=3): write addr 0x0000_0010 data 0xDEAD_BEEF accepted at edge N -> resp_valid high after edge N+3, resp_rdata=0, resp_err=0. Then read 0x0000_0010 -> resp_rdata=0xDEAD_BEEF after 3 cycles; wr_count=1, rd_count=1.
- Backpressure: read with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable all 5 cycles, req_ready=0; resp_ready=1 -> resp_valid drops next edge, req_ready=1 next cycle.
- Illegal addresses: read 0x0000_1000 (beyond 1024 words) -> resp_err=1, resp_rdata=0. Write 0x0000_0012 (misaligned) data 0x1234_5678 -> resp_err=1. A subsequent read of 0x0000_0010 still returns 0xDEAD_BEEF.
- Reset mid-WAIT: write 0x0000_0020 data 0xAAAA_5555, then pull rst_n low one cycle after acceptance -> no resp_valid, wr_count=0. After reset, write 0x0000_0020 data 0x1111_2222 and read it back -> 0x1111_2222.
- Counter saturation (CNT_W=4) and LATENCY=1: issue 17 reads -> rd_count reaches 15 and holds; each response appears one edge after acceptance.
